jt10_adpcma_dec: RTL and testbench

- ADPCM-A nibble decoder. Sits directly downstream of the ADPCM-A address counter.
- Consumes the ROM data byte fetched at the counter's address, plus its nibble select and read-enable.
- Six channels are time-multiplexed through one 6-slot circular pipeline, one slot per cen cycle.
- Produces a 12-bit signed PCM sample per slot for the ADPCM-A mixer.

---
 rtl/jt10_adpcma_dec.sv | 256 +++++++++++++++++++++++++
 tb/tb_jt10_adpcma_dec.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jt10_adpcma_dec.sv
// -----------------------------------------------------------------------------
// jt10_adpcma_dec
//
// ADPCM-A nibble decoder for six time-multiplexed channels. One channel (slot)
// is served per cen cycle. Each channel's decoder state (12-bit accumulator and
// 6-bit step index) travels around a 6-register ring, so a channel's state is
// back at the input stage exactly six cen cycles after it left. No RAM is used.
//
// Pipeline (each stage advances only when cen=1):
//   stage 1 : latch the nibble, en (~roe_n) and clr (aon) for the counter's slot,
//             pull that slot's acc/idx from the ring tail and look up STEP[idx].
//   stage 2 : delta = floor(step * (2*mag + 1) / 8), sign taken from nib[3].
//   stage 3 : clear / accumulate / hold; the result is pcm and re-enters the ring.
//   ring    : three further registers close the 6-deep loop.
//
// Slot timing contract: the inputs present at a cen edge belong to the slot held
// by the internal slot counter at that edge (0 right after reset, then
// 1,2,..,5,0,...). The pcm/pcm_slot pair for that sample appears after the third
// cen edge counting the sampling edge itself, and is replaced on every cen.
// There is no back-pressure.
//
// Build option:
//   JT10_ADPCMA_SAT_EN defined   : the accumulator update saturates to
//                                  -2048..+2047.
//   JT10_ADPCMA_SAT_EN undefined : 12-bit two's-complement wrap (chip accurate).
//   Step-index clamping to 0..48 applies in both builds.
//
// Parameters:
//   SLOTS    number of channels / ring depth (only 6 is supported)
//   ACCW     accumulator and pcm width (signed, 12)
//
// Ports:
//   clk       system clock
//   rst       asynchronous reset, active high
//   cen       clock enable; every register holds while low
//   data      ROM byte for the current slot
//   sel       nibble select: 0 = data[7:4], 1 = data[3:0]
//   roe_n     low = slot active, data valid
//   aon       key-on: clears the slot's channel state (wins over roe_n)
//   pcm       signed decoded sample of the slot leaving stage 3
//   pcm_slot  slot number (0..5) that pcm belongs to
// -----------------------------------------------------------------------------
module jt10_adpcma_dec #(
  parameter int SLOTS = 6,
  parameter int ACCW  = 12
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cen,
  input  logic [7:0]      data,
  input  logic            sel,
  input  logic            roe_n,
  input  logic            aon,
  output logic [ACCW-1:0] pcm,
  output logic [2:0]      pcm_slot
);

  localparam logic [2:0] LAST_SLOT = 3'(SLOTS - 1);
  localparam logic [5:0] IDX_MAX   = 6'd48;

  // ---------------------------------------------------------------------------
  // Step size table, indexed by the channel's step index (0..48).
  // ---------------------------------------------------------------------------
  function automatic logic [10:0] step_rom(input logic [5:0] idx);
    logic [10:0] s;
    case (idx)
      6'd0:  s = 11'd16;    6'd1:  s = 11'd17;    6'd2:  s = 11'd19;
      6'd3:  s = 11'd21;    6'd4:  s = 11'd23;    6'd5:  s = 11'd25;
      6'd6:  s = 11'd28;    6'd7:  s = 11'd31;    6'd8:  s = 11'd34;
      6'd9:  s = 11'd37;    6'd10: s = 11'd41;    6'd11: s = 11'd45;
      6'd12: s = 11'd50;    6'd13: s = 11'd55;    6'd14: s = 11'd60;
      6'd15: s = 11'd66;    6'd16: s = 11'd73;    6'd17: s = 11'd80;
      6'd18: s = 11'd88;    6'd19: s = 11'd97;    6'd20: s = 11'd107;
      6'd21: s = 11'd118;   6'd22: s = 11'd130;   6'd23: s = 11'd143;
      6'd24: s = 11'd157;   6'd25: s = 11'd173;   6'd26: s = 11'd190;
      6'd27: s = 11'd209;   6'd28: s = 11'd230;   6'd29: s = 11'd253;
      6'd30: s = 11'd279;   6'd31: s = 11'd307;   6'd32: s = 11'd337;
      6'd33: s = 11'd371;   6'd34: s = 11'd408;   6'd35: s = 11'd449;
      6'd36: s = 11'd494;   6'd37: s = 11'd544;   6'd38: s = 11'd598;
      6'd39: s = 11'd658;   6'd40: s = 11'd724;   6'd41: s = 11'd796;
      6'd42: s = 11'd876;   6'd43: s = 11'd963;   6'd44: s = 11'd1060;
      6'd45: s = 11'd1166;  6'd46: s = 11'd1282;  6'd47: s = 11'd1411;
      default: s = 11'd1552;  // 48; indices above 48 never occur
    endcase
    return s;
  endfunction

  // Step-index adjustment by nibble magnitude.
  function automatic logic signed [6:0] adj_rom(input logic [2:0] mag);
    logic signed [6:0] a;
    case (mag)
      3'd4:    a = 7'sd2;
      3'd5:    a = 7'sd5;
      3'd6:    a = 7'sd7;
      3'd7:    a = 7'sd9;
      default: a = -7'sd1;
    endcase
    return a;
  endfunction

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [2:0]      slot_cnt;

  // stage 1
  logic [2:0]      s1_slot;
  logic [3:0]      s1_nib;
  logic            s1_en;
  logic            s1_clr;
  logic [ACCW-1:0] s1_acc;
  logic [5:0]      s1_idx;
  logic [10:0]     s1_step;

  // stage 2
  logic [2:0]      s2_slot;
  logic            s2_en;
  logic            s2_clr;
  logic            s2_neg;
  logic [2:0]      s2_mag;
  logic [ACCW-1:0] s2_acc;
  logic [5:0]      s2_idx;
  logic [11:0]     s2_delta;

  // stage 3 (acc lives in pcm)
  logic [5:0]      s3_idx;

  // ring tail: three registers after stage 3 close the 6-deep loop
  logic [ACCW-1:0] ring_acc [0:2];
  logic [5:0]      ring_idx [0:2];

  // ---------------------------------------------------------------------------
  // Stage 2 arithmetic: step * (2*mag+1) is at most 1552*15 = 23280 (15 bits);
  // after the divide by 8 the delta fits in 12 bits.
  // ---------------------------------------------------------------------------
  logic [11:0] delta;
  assign delta = 12'((15'(s1_step) * 15'({s1_nib[2:0], 1'b1})) >> 3);

  // ---------------------------------------------------------------------------
  // Stage 3 update
  // ---------------------------------------------------------------------------
  logic [ACCW-1:0]   sum_acc;
  logic signed [6:0] idx_w;
  logic [5:0]        idx_clamped;
  logic [ACCW-1:0]   nxt_acc;
  logic [5:0]        nxt_idx;

`ifdef JT10_ADPCMA_SAT_EN
  // Two guard bits: |delta| reaches 2910, so acc+delta can exceed the 13-bit
  // signed range before it is clipped.
  localparam int SUMW = ACCW + 2;
  localparam logic signed [SUMW-1:0] ACC_MAX = SUMW'((1 << (ACCW - 1)) - 1);
  localparam logic signed [SUMW-1:0] ACC_MIN = SUMW'(-(1 << (ACCW - 1)));
  logic signed [SUMW-1:0] acc_ext;
  logic signed [SUMW-1:0] dlt_ext;
  logic signed [SUMW-1:0] sum_w;
`else
  logic [ACCW-1:0] dlt_w;
`endif

  always_comb begin
`ifdef JT10_ADPCMA_SAT_EN
    acc_ext = signed'({{2{s2_acc[ACCW-1]}}, s2_acc});
    dlt_ext = signed'({{(SUMW-12){1'b0}}, s2_delta});
    sum_w   = s2_neg ? (acc_ext - dlt_ext) : (acc_ext + dlt_ext);
    if (sum_w > ACC_MAX)      sum_acc = ACC_MAX[ACCW-1:0];
    else if (sum_w < ACC_MIN) sum_acc = ACC_MIN[ACCW-1:0];
    else                      sum_acc = sum_w[ACCW-1:0];
`else
    dlt_w   = ACCW'(s2_delta);
    sum_acc = s2_neg ? (s2_acc - dlt_w) : (s2_acc + dlt_w);
`endif

    idx_w = signed'({1'b0, s2_idx}) + adj_rom(s2_mag);
    if (idx_w < 7'sd0)                   idx_clamped = 6'd0;
    else if (idx_w > signed'({1'b0, IDX_MAX})) idx_clamped = IDX_MAX;
    else                                 idx_clamped = idx_w[5:0];

    // Key-on beats an active nibble; an inactive slot just carries its state.
    nxt_acc = s2_acc;
    nxt_idx = s2_idx;
    if (s2_clr) begin
      nxt_acc = '0;
      nxt_idx = '0;
    end else if (s2_en) begin
      nxt_acc = sum_acc;
      nxt_idx = idx_clamped;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt <= '0;
      s1_slot  <= '0;
      s1_nib   <= '0;
      s1_en    <= 1'b0;
      s1_clr   <= 1'b0;
      s1_acc   <= '0;
      s1_idx   <= '0;
      s1_step  <= '0;
      s2_slot  <= '0;
      s2_en    <= 1'b0;
      s2_clr   <= 1'b0;
      s2_neg   <= 1'b0;
      s2_mag   <= '0;
      s2_acc   <= '0;
      s2_idx   <= '0;
      s2_delta <= '0;
      s3_idx   <= '0;
      pcm      <= '0;
      pcm_slot <= '0;
      for (int i = 0; i < 3; i++) begin
        ring_acc[i] <= '0;
        ring_idx[i] <= '0;
      end
    end else if (cen) begin
      slot_cnt <= (slot_cnt == LAST_SLOT) ? 3'd0 : slot_cnt + 3'd1;

      // stage 1: inputs of the counter's slot meet that slot's ring state
      s1_slot <= slot_cnt;
      s1_nib  <= sel ? data[3:0] : data[7:4];
      s1_en   <= ~roe_n;
      s1_clr  <= aon;
      s1_acc  <= ring_acc[2];
      s1_idx  <= ring_idx[2];
      s1_step <= step_rom(ring_idx[2]);

      // stage 2
      s2_slot  <= s1_slot;
      s2_en    <= s1_en;
      s2_clr   <= s1_clr;
      s2_neg   <= s1_nib[3];
      s2_mag   <= s1_nib[2:0];
      s2_acc   <= s1_acc;
      s2_idx   <= s1_idx;
      s2_delta <= delta;

      // stage 3: result is both the output sample and the ring entry
      pcm      <= nxt_acc;
      pcm_slot <= s2_slot;
      s3_idx   <= nxt_idx;

      // ring tail
      ring_acc[0] <= pcm;
      ring_idx[0] <= s3_idx;
      ring_acc[1] <= ring_acc[0];
      ring_idx[1] <= ring_idx[0];
      ring_acc[2] <= ring_acc[1];
      ring_idx[2] <= ring_idx[1];
    end
  end

endmodule

// File: tb/tb_jt10_adpcma_dec.sv
// -----------------------------------------------------------------------------
// tb_jt10_adpcma_dec
//
// Directed bench for jt10_adpcma_dec. The driver issues one slot per cen cycle
// and, for checked slots, pushes {due edge, slot, expected pcm} into exp_q. A
// monitor on the falling edge pops every entry whose due edge has arrived and
// compares it with pcm/pcm_slot. Expected values are hand-computed from the
// step table and the ADJ table; entries that differ between the wrap and
// saturating builds are selected with JT10_ADPCMA_SAT_EN.
// -----------------------------------------------------------------------------
module tb_jt10_adpcma_dec;

  localparam int W = 31;  // {due[15:0], slot[2:0], pcm[11:0]}

`ifdef JT10_ADPCMA_SAT_EN
  localparam int EXP_G = 2047;
  localparam int EXP_H = 2047;
  localparam int EXP_I = 2047;
  localparam int EXP_J = 2047;
`else
  localparam int EXP_G = -329;   // 1581 + 2186 = 3767 wraps
  localparam int EXP_H = -1515;  // -329 + 2910 = 2581 wraps
  localparam int EXP_I = 1395;   // -1515 + 2910
  localparam int EXP_J = 209;    // 1395 + 2910 = 4305 wraps
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst;
  logic        cen;
  logic [7:0]  data;
  logic        sel;
  logic        roe_n;
  logic        aon;
  logic [11:0] pcm;
  logic [2:0]  pcm_slot;

  always #5 clk = ~clk;

  jt10_adpcma_dec dut (
    .clk      (clk),
    .rst      (rst),
    .cen      (cen),
    .data     (data),
    .sel      (sel),
    .roe_n    (roe_n),
    .aon      (aon),
    .pcm      (pcm),
    .pcm_slot (pcm_slot)
  );

  int edge_cnt;
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] ent;

  // cen edges since reset; the slot sampled on the next edge is edge_cnt % 6
  always @(posedge clk or posedge rst) begin
    if (rst) edge_cnt <= 0;
    else if (cen) edge_cnt <= edge_cnt + 1;
  end

  task automatic cmp(input string name, input logic [11:0] exp_pcm,
                     input logic [2:0] exp_slot);
    checks++;
    if (pcm !== exp_pcm || pcm_slot !== exp_slot) begin
      errors++;
      $display("FAIL %s: pcm=%0d slot=%0d, expected pcm=%0d slot=%0d",
               name, $signed(pcm), pcm_slot, $signed(exp_pcm), exp_slot);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic v(input logic [7:0] d, input logic s, input logic r,
                   input logic a, input int e, input bit chk);
    @(negedge clk);
    data  = d;
    sel   = s;
    roe_n = r;
    aon   = a;
    cen   = 1'b1;
    if (chk) exp_q.push_back({16'(edge_cnt + 3), 3'(edge_cnt % 6), 12'(e)});
  endtask

  // inactive slot with junk data: expects the held accumulator
  task automatic hold(input int e);
    v(8'hA5, 1'b0, 1'b1, 1'b0, e, 1'b1);
  endtask

  task automatic skip();
    v(8'h5A, 1'b1, 1'b1, 1'b0, 0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 12 && exp_q.size() > 0; i++) begin
      @(negedge clk);
      roe_n = 1'b1;
      aon   = 1'b0;
      cen   = 1'b1;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d samples outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard monitor
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (!rst) begin
      while (exp_q.size() > 0) begin
        ent = exp_q[0];
        if (int'(ent[30:15]) > edge_cnt) break;
        void'(exp_q.pop_front());
        if (int'(ent[30:15]) < edge_cnt) begin
          checks++;
          errors++;
          $display("FAIL late: due edge %0d seen at edge %0d", ent[30:15], edge_cnt);
        end else begin
          cmp($sformatf("sample_slot%0d", ent[14:12]), ent[11:0], ent[14:12]);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b1; cen = 1'b0; data = 8'h00; sel = 1'b0; roe_n = 1'b1; aon = 1'b0;
    #12;
    cmp("reset_state", 12'd0, 3'd0);
    @(negedge clk);
    rst = 1'b0;

    // A: key-on every slot
    for (int i = 0; i < 6; i++) v(8'h00, 1'b0, 1'b1, 1'b1, 0, 1'b1);
    // B: first nibbles (step 16 everywhere)
    v(8'h00, 1'b0, 1'b0, 1'b0, 2, 1'b1);     // s0 nib0: +2
    v(8'h08, 1'b1, 1'b0, 1'b0, -2, 1'b1);    // s1 nib8: -2
    v(8'h70, 1'b0, 1'b0, 1'b0, 30, 1'b1);    // s2 nib7: +30, idx 9
    v(8'h07, 1'b1, 1'b0, 1'b0, 30, 1'b1);    // s3 nib7: +30, idx 9
    hold(0);                                 // s4
    v(8'h10, 1'b0, 1'b0, 1'b0, 6, 1'b1);     // s5 nib1: +6
    // C
    v(8'h70, 1'b0, 1'b0, 1'b0, 32, 1'b1);    // s0 idx0 -> 2+30, idx 9
    v(8'h07, 1'b1, 1'b0, 1'b0, 28, 1'b1);    // s1 -2+30
    v(8'h07, 1'b1, 1'b0, 1'b0, 99, 1'b1);    // s2 step37 delta69, idx 18
    v(8'hF0, 1'b0, 1'b0, 1'b0, -39, 1'b1);   // s3 nibF: 30-69, idx 18
    hold(0);                                 // s4
    v(8'h04, 1'b1, 1'b0, 1'b0, 24, 1'b1);    // s5 nib4: 6+18, idx 2
    // D
    v(8'h00, 1'b1, 1'b0, 1'b0, 36, 1'b1);    // s0 step37 nib0: +4, idx 8
    v(8'h77, 1'b0, 1'b1, 1'b0, 28, 1'b1);    // s1 inactive: holds
    v(8'h7A, 1'b0, 1'b0, 1'b0, 264, 1'b1);   // s2 step88 delta165, idx 27
    v(8'h3F, 1'b0, 1'b0, 1'b0, 38, 1'b1);    // s3 nib3 step88: +77, idx 17
    v(8'h77, 1'b0, 1'b0, 1'b1, 0, 1'b1);     // s4 aon with active nibble: 0
    v(8'h0C, 1'b1, 1'b0, 1'b0, 3, 1'b1);     // s5 nibC step19: -21, idx 4
    // E
    v(8'h10, 1'b0, 1'b0, 1'b0, 48, 1'b1);    // s0 nib1 step34: +12, idx 7
    v(8'hFF, 1'b1, 1'b1, 1'b0, 28, 1'b1);    // s1 inactive
    v(8'h07, 1'b1, 1'b0, 1'b0, 655, 1'b1);   // s2 step209 delta391, idx 36
    hold(38);                                // s3
    hold(0);                                 // s4
    v(8'h02, 1'b1, 1'b0, 1'b0, 17, 1'b1);    // s5 nib2 step23: +14, idx 3
    // F..J: keep feeding nibble 7 to slot 2 into overflow
    hold(48); hold(28);
    v(8'h70, 1'b0, 1'b0, 1'b0, 1581, 1'b1);  // step494 delta926, idx 45
    hold(38); hold(0); hold(17);
    hold(48); hold(28);
    v(8'h70, 1'b0, 1'b0, 1'b0, EXP_G, 1'b1); // step1166 delta2186, idx 48
    hold(38); hold(0); hold(17);
    hold(48); hold(28);
    v(8'h70, 1'b0, 1'b0, 1'b0, EXP_H, 1'b1); // step1552 delta2910, idx 48
    hold(38); hold(0); hold(17);
    hold(48); hold(28);
    v(8'h70, 1'b0, 1'b0, 1'b0, EXP_I, 1'b1);
    hold(38); hold(0); hold(17);
    hold(48); hold(28);
    v(8'h70, 1'b0, 1'b0, 1'b0, EXP_J, 1'b1);
    hold(38); hold(0); hold(17);
    // K: key-on together with an active nibble on slot 2
    hold(48); hold(28);
    v(8'h77, 1'b0, 1'b0, 1'b1, 0, 1'b1);
    hold(38); hold(0); hold(17);
    // L: index was cleared too, so nibble 7 gives +30 again
    hold(48); hold(28);
    v(8'h70, 1'b0, 1'b0, 1'b0, 30, 1'b1);
    skip(); skip();

    // cen low: slot 2's +30 stays on the outputs
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      cen = 1'b0;
      cmp("cen_low", 12'd30, 3'd2);
    end

    // async reset mid-stream
    skip();                                  // slot 5 sampled, slot 3 emerges
    @(posedge clk);
    #2;
    cmp("pre_reset", 12'd38, 3'd3);
    rst = 1'b1;
    #1;
    cmp("async_reset", 12'd0, 3'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cen = 1'b0;

    // restart from slot 0 with every channel cleared
    v(8'h70, 1'b0, 1'b0, 1'b0, 30, 1'b1);    // s0 idx0: +30
    hold(0);                                 // s1
    v(8'h08, 1'b1, 1'b0, 1'b0, -2, 1'b1);    // s2 was 30 before reset
    hold(0);                                 // s3 was 38 before reset
    hold(0);
    hold(0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
